clock_display: RTL

- Display-side consumer of the time-of-day counter outputs (sec/min/hr, binary).
- Detects any change in the time value and converts each field to two BCD digits with a sequential shift-and-add-3 (double-dabble) engine.
- Drives six registered 7-segment digit outputs: HEX5..HEX0 = HH MM SS.
- Sits between the time-of-day counter and the board seven-segment pins.

---
 rtl/clock_display_pkg.sv | 40 ++++
 rtl/clock_display_if.sv | 31 +++
 rtl/clock_display_seg7_decode.sv | 36 +++
 rtl/clock_display.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// clock_display_pkg
// Shared definitions for the clock display block: FSM state encoding,
// active-high seven-segment digit patterns (bit0 = seg a .. bit6 = seg g),
// the number of double-dabble steps, and the BCD digit-adjust helper.
package clock_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Every field is presented to the converter as 6 binary bits.
    localparam int CONV_STEPS = 6;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decade.
    function automatic logic [7:0] dd_adjust(input logic [7:0] bcd);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = bcd[3:0];
        hi = bcd[7:4];
        if (lo >= 4'd5) lo = lo + 4'd3;
        if (hi >= 4'd5) hi = hi + 4'd3;
        return {hi, lo};
    endfunction

endpackage

// File: rtl/clock_display_if.sv
// clock_display_if
// Bundles the time-of-day value feeding the display and the display-side
// results.
//   sec, min (6b), hr (5b) : binary time from the time-of-day counter
//   HEX0..HEX5 (7b)        : segment patterns, HEX5..HEX0 = HH MM SS
//   busy                   : a conversion is in flight
//   upd                    : one-cycle pulse when the HEX outputs change
// master = time source / observer side, slave = the display block.
interface clock_display_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic       busy;
    logic       upd;

    modport master (
        output sec, min, hr,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, upd
    );

    modport slave (
        input  sec, min, hr,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, upd
    );
endinterface

// File: rtl/clock_display_seg7_decode.sv
// seg7_decode
// Combinational BCD digit to seven-segment pattern.
//   bcd (in, 4b)  : BCD digit 0..9; codes above 9 give a blank digit
//   seg (out, 7b) : bit0 = seg a .. bit6 = seg g
// ACTIVE_LOW = 1 inverts the pattern so a lit segment is driven as 0.
module seg7_decode
    import clock_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = SEG_BLANK;
        case (bcd)
            4'd0:    seg_hi = SEG_0;
            4'd1:    seg_hi = SEG_1;
            4'd2:    seg_hi = SEG_2;
            4'd3:    seg_hi = SEG_3;
            4'd4:    seg_hi = SEG_4;
            4'd5:    seg_hi = SEG_5;
            4'd6:    seg_hi = SEG_6;
            4'd7:    seg_hi = SEG_7;
            4'd8:    seg_hi = SEG_8;
            4'd9:    seg_hi = SEG_9;
            default: seg_hi = SEG_BLANK;
        endcase
    end

    assign seg = ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/clock_display.sv
// clock_display
// Watches the binary time-of-day value, and whenever it differs from the
// last value converted, runs a sequential double-dabble conversion of all
// three fields in parallel and registers six seven-segment digits.
//   clk  : system clock, all state on posedge
//   rst  : synchronous reset, active-high; discards any conversion
//   bus  : clock_display_if.slave (sec/min/hr in; HEX0..HEX5, busy, upd out)
// Parameter ACTIVE_LOW: 1 = segment lit when its bit is 0.
// Optional macro CLOCK_DISPLAY_BLANK_EN: when defined, a conversion result
// with an hours tens digit of 0 blanks HEX5 (leading-zero suppression).
module clock_display
    import clock_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    clock_display_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_CONV   = 2'(CONV);
    localparam logic [1:0] ST_DONE   = 2'(DONE);
    localparam logic [2:0] LAST_STEP = 3'(CONV_STEPS - 1);
    localparam logic [6:0] ZERO_OUT  = ACTIVE_LOW ? ~SEG_0 : SEG_0;
`ifdef CLOCK_DISPLAY_BLANK_EN
    localparam logic [6:0] OFF_OUT   = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
`endif

    logic [1:0] state;
    logic [2:0] step_cnt;

    // Last value handed to the converter; a difference triggers a new run.
    logic [5:0] sec_shadow;
    logic [5:0] min_shadow;
    logic [4:0] hr_shadow;

    // Binary shift registers and BCD accumulators, one pair per field.
    logic [5:0] sec_sr;
    logic [5:0] min_sr;
    logic [5:0] hr_sr;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;

    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic       busy;
    logic       upd;

    logic [6:0] seg_s0;
    logic [6:0] seg_s1;
    logic [6:0] seg_m0;
    logic [6:0] seg_m1;
    logic [6:0] seg_h0;
    logic [6:0] seg_h1;

    logic       changed;

    assign changed = {bus.sec, bus.min, bus.hr} != {sec_shadow, min_shadow, hr_shadow};

    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_s0 (.bcd(sec_bcd[3:0]), .seg(seg_s0));
    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_s1 (.bcd(sec_bcd[7:4]), .seg(seg_s1));
    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_m0 (.bcd(min_bcd[3:0]), .seg(seg_m0));
    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_m1 (.bcd(min_bcd[7:4]), .seg(seg_m1));
    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_h0 (.bcd(hr_bcd[3:0]),  .seg(seg_h0));
    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_h1 (.bcd(hr_bcd[7:4]),  .seg(seg_h1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step_cnt   <= 3'd0;
            sec_shadow <= 6'd0;
            min_shadow <= 6'd0;
            hr_shadow  <= 5'd0;
            sec_sr     <= 6'd0;
            min_sr     <= 6'd0;
            hr_sr      <= 6'd0;
            sec_bcd    <= 8'd0;
            min_bcd    <= 8'd0;
            hr_bcd     <= 8'd0;
            hex0       <= ZERO_OUT;
            hex1       <= ZERO_OUT;
            hex2       <= ZERO_OUT;
            hex3       <= ZERO_OUT;
            hex4       <= ZERO_OUT;
            hex5       <= ZERO_OUT;
            busy       <= 1'b0;
            upd        <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Inputs are only looked at here, so changes arriving
                    // mid-conversion are picked up on the next idle cycle.
                    if (changed) begin
                        sec_shadow <= bus.sec;
                        min_shadow <= bus.min;
                        hr_shadow  <= bus.hr;
                        sec_sr     <= bus.sec;
                        min_sr     <= bus.min;
                        hr_sr      <= {1'b0, bus.hr};  // zero pad: 6 steps for all
                        sec_bcd    <= 8'd0;
                        min_bcd    <= 8'd0;
                        hr_bcd     <= 8'd0;
                        step_cnt   <= 3'd0;
                        state      <= ST_CONV;
                        busy       <= 1'b1;
                    end
                end
                ST_CONV: begin
                    // Adjust, then shift the binary MSB into BCD bit 0.
                    {sec_bcd, sec_sr} <= {dd_adjust(sec_bcd), sec_sr} << 1;
                    {min_bcd, min_sr} <= {dd_adjust(min_bcd), min_sr} << 1;
                    {hr_bcd,  hr_sr}  <= {dd_adjust(hr_bcd),  hr_sr}  << 1;
                    if (step_cnt == LAST_STEP) begin
                        state <= ST_DONE;
                    end else begin
                        step_cnt <= step_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    hex0  <= seg_s0;
                    hex1  <= seg_s1;
                    hex2  <= seg_m0;
                    hex3  <= seg_m1;
                    hex4  <= seg_h0;
`ifdef CLOCK_DISPLAY_BLANK_EN
                    hex5  <= (hr_bcd[7:4] == 4'd0) ? OFF_OUT : seg_h1;
`else
                    hex5  <= seg_h1;
`endif
                    upd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.HEX0 = hex0;
    assign bus.HEX1 = hex1;
    assign bus.HEX2 = hex2;
    assign bus.HEX3 = hex3;
    assign bus.HEX4 = hex4;
    assign bus.HEX5 = hex5;
    assign bus.busy = busy;
    assign bus.upd  = upd;

endmodule
